// File: rtl/key_stream_arb_if.sv
// ---------------------------------------------------------------------------
// key_stream_arb_if
// Purpose : bundles the two source byte streams, the merged output stream and
//           the timeout strobe of key_stream_arb into one interface.
// Signals : i_kbd_byte/i_kbd_valid/o_kbd_ready    keyboard stream
//           i_host_byte/i_host_valid/o_host_ready host (uart_rx) stream
//           o_byte/o_valid/i_ready/o_src           merged output stream
//           o_timeout                              held-sequence abort pulse
// Modports: slave  - the arbiter's view (names are i_/o_ from its side)
//           master - the surrounding environment's view
// ---------------------------------------------------------------------------
interface key_stream_arb_if;
  logic [7:0] i_kbd_byte;
  logic       i_kbd_valid;
  logic       o_kbd_ready;
  logic [7:0] i_host_byte;
  logic       i_host_valid;
  logic       o_host_ready;
  logic [7:0] o_byte;
  logic       o_valid;
  logic       i_ready;
  logic       o_src;
  logic       o_timeout;

  modport slave (
    input  i_kbd_byte, i_kbd_valid, i_host_byte, i_host_valid, i_ready,
    output o_kbd_ready, o_host_ready, o_byte, o_valid, o_src, o_timeout
  );

  modport master (
    output i_kbd_byte, i_kbd_valid, i_host_byte, i_host_valid, i_ready,
    input  o_kbd_ready, o_host_ready, o_byte, o_valid, o_src, o_timeout
  );
endinterface

// File: rtl/key_stream_arb.sv
// ---------------------------------------------------------------------------
// key_stream_arb
// Purpose : merges keyboard bytes and host bytes into the terminal's single
//           input stream. Round-robin per byte, but an escape sequence
//           (ESC, or ESC [ ... final) keeps the grant with its source until
//           it completes or sits idle for HOLD_TIMEOUT cycles.
// Ports   : i_clk  12 MHz clock
//           i_rst  synchronous active-high reset
//           bus    key_stream_arb_if.slave (both sources, output, o_timeout)
// ---------------------------------------------------------------------------
module key_stream_arb #(
  parameter int         HOLD_TIMEOUT = 1200,
  parameter logic [7:0] ESC_CODE     = 8'h1B,
  parameter logic [7:0] CSI_CODE     = 8'h5B
) (
  input logic             i_clk,
  input logic             i_rst,
  key_stream_arb_if.slave bus
);

  localparam int              CW       = $clog2(HOLD_TIMEOUT + 1);
  localparam logic [CW-1:0]   LAST_CNT = CW'(HOLD_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ESC_HOLD = 2'd1,
    ST_CSI_HOLD = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_owner;
  logic          r_rr_last;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_byte;
  logic          r_valid;
  logic          r_src;

  logic          w_held;
  logic          w_slot_free;
  logic          w_sel;
  logic          w_sel_valid;
  logic [7:0]    w_sel_byte;
  logic          w_xfer;
  logic          w_timeout;

  // CSI parameter/intermediate bytes keep the sequence open
  function automatic logic is_csi_param(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h3F);
  endfunction

  // Source selection, handshake and timeout decode
  always_comb begin
    w_held      = (r_state != ST_IDLE);
    w_slot_free = !r_valid || bus.i_ready;
    w_sel       = r_owner;
    if (w_held) begin
      // a held sequence ignores the other source entirely
      w_sel = r_owner;
    end else if (bus.i_kbd_valid && bus.i_host_valid) begin
      w_sel = !r_rr_last;
    end else if (bus.i_kbd_valid) begin
      w_sel = 1'b0;
    end else if (bus.i_host_valid) begin
      w_sel = 1'b1;
    end else begin
      w_sel = r_owner;
    end
    w_sel_valid = w_sel ? bus.i_host_valid : bus.i_kbd_valid;
    w_sel_byte  = w_sel ? bus.i_host_byte  : bus.i_kbd_byte;
    w_xfer      = w_sel_valid && w_slot_free;
    // an owner byte arriving on the last allowed cycle rescues the sequence
    w_timeout   = w_held && !w_xfer && (r_cnt == LAST_CNT);
  end

  // Sequence FSM, output register and hold-timeout counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_owner   <= 1'b0;
      r_rr_last <= 1'b1;
      r_cnt     <= '0;
      r_byte    <= 8'h00;
      r_valid   <= 1'b0;
      r_src     <= 1'b0;
    end else if (w_xfer) begin
      r_byte    <= w_sel_byte;
      r_src     <= w_sel;
      r_valid   <= 1'b1;
      r_owner   <= w_sel;
      r_rr_last <= w_sel;
      r_cnt     <= '0;
      case (r_state)
        ST_IDLE: begin
          r_state <= (w_sel_byte == ESC_CODE) ? ST_ESC_HOLD : ST_IDLE;
        end
        ST_ESC_HOLD: begin
          if (w_sel_byte == CSI_CODE) begin
            r_state <= ST_CSI_HOLD;
          end else if (w_sel_byte == ESC_CODE) begin
            r_state <= ST_ESC_HOLD;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_CSI_HOLD: begin
          // final bytes and malformed bytes both end the sequence
          r_state <= is_csi_param(w_sel_byte) ? ST_CSI_HOLD : ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end else begin
      if (bus.i_ready) begin
        r_valid <= 1'b0;
      end
      if (w_timeout) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else if (w_held) begin
        // stalled cycles count too: the consumer cannot extend a hold
        r_cnt <= r_cnt + CW'(1);
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign bus.o_kbd_ready  = w_slot_free && !w_sel;
  assign bus.o_host_ready = w_slot_free && w_sel;
  assign bus.o_byte       = r_byte;
  assign bus.o_valid      = r_valid;
  assign bus.o_src        = r_src;
  assign bus.o_timeout    = w_timeout;

endmodule

// File: tb/tb_key_stream_arb.sv
// ---------------------------------------------------------------------------
// tb_key_stream_arb
// Purpose : self-checking bench for key_stream_arb: a vector table for the
//           basic merge/hold/stall behaviour, hand-written sequences for the
//           gap, timeout and reset corners, and a randomized run checked by
//           a stream-level reference model (per-source byte queues plus an
//           escape-sequence tracker and idle-cycle timer).
// ---------------------------------------------------------------------------
module tb_key_stream_arb;
  localparam int         HT  = 40;
  localparam logic [7:0] ESC = 8'h1B;
  localparam logic [7:0] CSI = 8'h5B;

  logic clk = 1'b0;
  logic rst;

  key_stream_arb_if bus();

  key_stream_arb #(.HOLD_TIMEOUT(HT), .ESC_CODE(ESC), .CSI_CODE(CSI)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       kv;  logic [7:0] kb;
    logic       hv;  logic [7:0] hb;
    logic       rdy;
    logic       ekr; logic ehr; logic eov; logic [7:0] eob; logic eos;
  } vec_t;

  typedef struct { logic [7:0] b; int gap; } item_t;

  vec_t       vecs[$];
  item_t      kq[$], hq[$];
  int         kgap, hgap;
  logic [7:0] expq0[$], expq1[$];
  logic [8:0] log_q[$];
  int         n_checks = 0, n_fail = 0;
  int         cyc, rdy_prob;
  int         phase;          // 0 none, 1 after ESC, 2 inside CSI
  logic       m_owner, m_last;
  int         last_acc;
  logic       pend, pend_s;
  logic [7:0] pend_b;
  int         to_count, to_cyc, k_acc_cyc, h_acc_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic kv, input logic [7:0] kb, input logic hv, input logic [7:0] hb,
                     input logic rdy, input logic ekr, input logic ehr, input logic eov,
                     input logic [7:0] eob, input logic eos);
    vec_t v;
    v.kv = kv; v.kb = kb; v.hv = hv; v.hb = hb; v.rdy = rdy;
    v.ekr = ekr; v.ehr = ehr; v.eov = eov; v.eob = eob; v.eos = eos;
    vecs.push_back(v);
  endtask

  task automatic push_k(input logic [7:0] b, input int gap);
    item_t it;
    it.b = b; it.gap = gap;
    if (kq.size() == 0) kgap = gap;
    kq.push_back(it);
  endtask

  task automatic push_h(input logic [7:0] b, input int gap);
    item_t it;
    it.b = b; it.gap = gap;
    if (hq.size() == 0) hgap = gap;
    hq.push_back(it);
  endtask

  task automatic model_reset();
    phase = 0; m_owner = 1'b0; m_last = 1'b1; last_acc = 0; pend = 1'b0;
    expq0.delete(); expq1.delete(); kq.delete(); hq.delete(); log_q.delete();
    kgap = 0; hgap = 0; cyc = 0;
    to_count = 0; to_cyc = -1; k_acc_cyc = -1; h_acc_cyc = -1;
  endtask

  task automatic dut_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.i_kbd_valid = 1'b0; bus.i_kbd_byte = 8'h00;
    bus.i_host_valid = 1'b0; bus.i_host_byte = 8'h00;
    bus.i_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    r = $urandom_range(99);
    if (r < 25)      return ESC;
    else if (r < 45) return CSI;
    else if (r < 70) return 8'($urandom_range(8'h3F, 8'h20));
    else if (r < 92) return 8'($urandom_range(8'h7E, 8'h40));
    else             return 8'($urandom_range(255, 0));
  endfunction

  // model: record an accepted byte and advance the escape-sequence tracker
  task automatic accept(input logic src, input logic [7:0] b);
    if (src) begin expq1.push_back(b); h_acc_cyc = cyc; end
    else     begin expq0.push_back(b); k_acc_cyc = cyc; end
    case (phase)
      0: phase = (b == ESC) ? 1 : 0;
      1: phase = (b == CSI) ? 2 : ((b == ESC) ? 1 : 0);
      2: phase = (b >= 8'h20 && b <= 8'h3F) ? 2 : 0;
      default: phase = 0;
    endcase
    m_owner = src; m_last = src; last_acc = cyc;
  endtask

  // one clock of queue-driven stimulus with full model checking
  task automatic cycle();
    logic kv, hv, kr, hr, ov, os, vto, rdy, slot, sel, kacc, hacc, oacc, exp_to;
    logic [7:0] ob, kb, hb;
    @(negedge clk);
    kv = (kq.size() > 0) && (kgap == 0);
    hv = (hq.size() > 0) && (hgap == 0);
    kb = 8'h00; hb = 8'h00;
    if (kv) kb = kq[0].b;
    if (hv) hb = hq[0].b;
    rdy = ($urandom_range(99) < rdy_prob);
    bus.i_kbd_valid = kv; bus.i_kbd_byte = kb;
    bus.i_host_valid = hv; bus.i_host_byte = hb;
    bus.i_ready = rdy;
    #1;
    kr = bus.o_kbd_ready; hr = bus.o_host_ready;
    ov = bus.o_valid; ob = bus.o_byte; os = bus.o_src; vto = bus.o_timeout;
    chk("ready_exclusive", kr & hr, 1'b0);
    if (pend) begin
      chk("latency_valid", ov, 1'b1);
      chk("latency_byte", {os, ob}, {pend_s, pend_b});
    end
    slot = !ov || rdy;
    if (phase != 0) begin
      chk("held_kbd_ready", kr, slot & !m_owner);
      chk("held_host_ready", hr, slot & m_owner);
    end else if (kv || hv) begin
      sel = (kv && hv) ? !m_last : hv;
      chk("rr_kbd_ready", kr, slot & !sel);
      chk("rr_host_ready", hr, slot & sel);
    end
    if (ov && rdy) begin
      log_q.push_back({os, ob});
      if (os) begin
        chk("out_host_known", expq1.size() != 0, 1'b1);
        if (expq1.size() != 0) chk("out_host_order", ob, expq1.pop_front());
      end else begin
        chk("out_kbd_known", expq0.size() != 0, 1'b1);
        if (expq0.size() != 0) chk("out_kbd_order", ob, expq0.pop_front());
      end
    end
    kacc = kv && kr;
    hacc = hv && hr;
    oacc = (phase != 0) && (m_owner ? hacc : kacc);
    exp_to = (phase != 0) && !oacc && (cyc - last_acc == HT);
    chk("timeout_pulse", vto, exp_to);
    if (vto) begin to_count++; to_cyc = cyc; end
    if (phase != 0) chk("no_interleave", m_owner ? kacc : hacc, 1'b0);
    if (exp_to) phase = 0;
    if (kacc) accept(1'b0, kb);
    if (hacc) accept(1'b1, hb);
    pend = kacc || hacc;
    pend_s = hacc; pend_b = hacc ? hb : kb;
    @(posedge clk);
    if (kacc) begin void'(kq.pop_front()); kgap = (kq.size() > 0) ? kq[0].gap : 0; end
    else if (!kv && kgap > 0) kgap--;
    if (hacc) begin void'(hq.pop_front()); hgap = (hq.size() > 0) ? hq[0].gap : 0; end
    else if (!hv && hgap > 0) hgap--;
    cyc++;
  endtask

  logic [8:0] exp_log [7];

  initial begin
    rst = 1'b1;
    bus.i_kbd_valid = 1'b0; bus.i_kbd_byte = 8'h00;
    bus.i_host_valid = 1'b0; bus.i_host_byte = 8'h00;
    bus.i_ready = 1'b1;
    rdy_prob = 100;

    //       kv kb     hv hb     rdy kr hr ov ob     os
    add(1'b1, 8'h41, 1'b1, 8'h61, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    add(1'b1, 8'h42, 1'b1, 8'h61, 1'b1, 1'b0, 1'b1, 1'b1, 8'h41, 1'b0);
    add(1'b1, 8'h42, 1'b1, 8'h62, 1'b1, 1'b1, 1'b0, 1'b1, 8'h61, 1'b1);
    add(1'b0, 8'h00, 1'b1, 8'h62, 1'b1, 1'b0, 1'b1, 1'b1, 8'h42, 1'b0);
    add(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h62, 1'b1);
    add(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h62, 1'b1);
    // cursor-up from the keyboard while the host byte waits
    add(1'b1, 8'h1B, 1'b1, 8'h78, 1'b1, 1'b1, 1'b0, 1'b0, 8'h62, 1'b1);
    add(1'b1, 8'h5B, 1'b1, 8'h78, 1'b1, 1'b1, 1'b0, 1'b1, 8'h1B, 1'b0);
    add(1'b1, 8'h41, 1'b1, 8'h78, 1'b1, 1'b1, 1'b0, 1'b1, 8'h5B, 1'b0);
    add(1'b0, 8'h00, 1'b1, 8'h78, 1'b1, 1'b0, 1'b1, 1'b1, 8'h41, 1'b0);
    add(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h78, 1'b1);
    add(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h78, 1'b1);
    // consumer stall for 10 cycles with 8'h41 on the output
    add(1'b1, 8'h41, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h78, 1'b1);
    for (int i = 0; i < 10; i++)
      add(1'b1, 8'h42, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h41, 1'b0);
    add(1'b1, 8'h42, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h41, 1'b0);
    add(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h42, 1'b0);
    add(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h42, 1'b0);

    // reset state
    dut_reset();
    #1;
    chk("reset_valid", bus.o_valid, 1'b0);
    chk("reset_byte", bus.o_byte, 8'h00);
    chk("reset_src", bus.o_src, 1'b0);
    chk("reset_timeout", bus.o_timeout, 1'b0);

    // vector table
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      bus.i_kbd_valid = vecs[i].kv; bus.i_kbd_byte = vecs[i].kb;
      bus.i_host_valid = vecs[i].hv; bus.i_host_byte = vecs[i].hb;
      bus.i_ready = vecs[i].rdy;
      #1;
      chk($sformatf("vec%0d_kbd_ready", i), bus.o_kbd_ready, vecs[i].ekr);
      chk($sformatf("vec%0d_host_ready", i), bus.o_host_ready, vecs[i].ehr);
      chk($sformatf("vec%0d_valid", i), bus.o_valid, vecs[i].eov);
      chk($sformatf("vec%0d_byte", i), bus.o_byte, vecs[i].eob);
      chk($sformatf("vec%0d_src", i), bus.o_src, vecs[i].eos);
      chk($sformatf("vec%0d_timeout", i), bus.o_timeout, 1'b0);
    end

    // long CSI sequence with 3-cycle gaps while the host waits
    dut_reset();
    push_h(8'h55, 0);
    push_k(8'h1B, 0); push_k(8'h5B, 3); push_k(8'h31, 3);
    push_k(8'h3B, 3); push_k(8'h35, 3); push_k(8'h44, 3);
    for (int g = 0; g < 200 && (kq.size() + hq.size()) > 0; g++) cycle();
    cycle(); cycle();
    exp_log[0] = {1'b0, 8'h1B}; exp_log[1] = {1'b0, 8'h5B}; exp_log[2] = {1'b0, 8'h31};
    exp_log[3] = {1'b0, 8'h3B}; exp_log[4] = {1'b0, 8'h35}; exp_log[5] = {1'b0, 8'h44};
    exp_log[6] = {1'b1, 8'h55};
    chk("gap_seq_count", log_q.size(), 7);
    for (int i = 0; i < 7; i++)
      if (i < log_q.size()) chk($sformatf("gap_seq_byte%0d", i), log_q[i], exp_log[i]);
    chk("gap_seq_no_timeout", to_count, 0);

    // lone ESC: grant released by timeout, host byte follows
    dut_reset();
    push_k(8'h1B, 0);
    push_h(8'h7A, 0);
    for (int g = 0; g < 4 * HT && hq.size() > 0; g++) cycle();
    cycle(); cycle();
    chk("to_host_done", hq.size(), 0);
    chk("to_pulse_count", to_count, 1);
    chk("to_pulse_delay", to_cyc - k_acc_cyc, HT);
    chk("to_host_after", h_acc_cyc - to_cyc, 1);
    chk("to_last_out", (log_q.size() > 0) ? log_q[log_q.size() - 1] : 9'h000, {1'b1, 8'h7A});

    // reset in the middle of a CSI sequence
    dut_reset();
    push_k(8'h1B, 0); push_k(8'h5B, 0);
    for (int g = 0; g < 20 && kq.size() > 0; g++) cycle();
    @(negedge clk);
    #1;
    chk("csi_pre_valid", bus.o_valid, 1'b1);
    chk("csi_pre_byte", bus.o_byte, 8'h5B);
    rst = 1'b1;
    bus.i_kbd_valid = 1'b0; bus.i_host_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    bus.i_host_valid = 1'b1; bus.i_host_byte = 8'h30;
    #1;
    chk("rst_mid_valid", bus.o_valid, 1'b0);
    chk("rst_mid_host_ready", bus.o_host_ready, 1'b1);
    chk("rst_mid_kbd_ready", bus.o_kbd_ready, 1'b0);
    @(negedge clk);
    bus.i_host_valid = 1'b0;
    #1;
    chk("rst_host_valid", bus.o_valid, 1'b1);
    chk("rst_host_byte", bus.o_byte, 8'h30);
    chk("rst_host_src", bus.o_src, 1'b1);

    // randomized traffic against the reference model
    dut_reset();
    rdy_prob = 75;
    for (int i = 0; i < 250; i++) begin
      push_k(rand_byte(), ($urandom_range(99) < 4) ? int'($urandom_range(HT + 20, HT - 10)) : int'($urandom_range(2, 0)));
      push_h(rand_byte(), ($urandom_range(99) < 4) ? int'($urandom_range(HT + 20, HT - 10)) : int'($urandom_range(2, 0)));
    end
    for (int g = 0; g < 30000 && (kq.size() + hq.size()) > 0; g++) cycle();
    rdy_prob = 100;
    for (int i = 0; i < 4; i++) cycle();
    chk("rand_all_sent", kq.size() + hq.size(), 0);
    chk("rand_kbd_drained", expq0.size(), 0);
    chk("rand_host_drained", expq1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
